ws2812_rx: RTL
==============

# ws2812_rx

Single-wire WS2812 stream decoder: the receive-side counterpart of the team's LED driver. Samples the PWM line, classifies each high pulse as a 0 or 1, assembles MSB-first 24-bit GRB words, and detects the latch gap that ends a frame. Used for driver loopback self-test and as the front end of a pass-through node that consumes pixels from an upstream strip. Runs at 20 MHz; all thresholds are in clk cycles.

## Interface
- NUM_LEDS, 60: maximum pixels accepted per frame.
- T_RUNT, 4: high widths below this are errors.
- T_SPLIT, 12: high width >= this decodes 1, below decodes 0.
- T_MAX, 20: high width above this is an error (stuck high).
- RESET_CYCLES, 1000: low run (50 us) that marks a latch gap.
- IDX_W, $clog2(NUM_LEDS): pixel index width.

Ports:
- clk  in  1  system clock, 20 MHz.
- reset  in  1  synchronous, active-high.
- din  in  1  asynchronous serial line.
- pixel  out  24  last decoded word, first received bit in [23].
- pixel_valid  out  1  one-cycle strobe, pixel and pixel_idx valid.
- pixel_idx  out  IDX_W  position of pixel in the current frame, 0-based.
- frame_done  out  1  one-cycle strobe on latch gap after at least one bit.
- err  out  1  one-cycle strobe on any protocol violation.

## Operation
- din passes through a two-flop synchronizer. din_s is the second flop; din_q is din_s delayed one cycle. All counting uses din_s.
- States:
  - WAIT_GAP: entered on reset and after stuck-high errors. lcnt counts consecutive din_s-low cycles and clears on high. At lcnt == RESET_CYCLES: go to LOW and clear idx and bitcnt. No frame_done is issued here. This state prevents joining a stream mid-frame.
  - LOW:
    - Rising edge (din_s & ~din_q): go to HIGH with hcnt = 1 and lcnt = 0.
    - Otherwise lcnt increments and saturates at RESET_CYCLES.
    - When lcnt first reaches RESET_CYCLES with bitcnt != 0 or idx != 0: pulse frame_done. Also pulse err if bitcnt != 0, discarding the partial word. Then clear idx and bitcnt.
  - HIGH:
    - hcnt increments each high cycle.
    - If hcnt exceeds T_MAX: pulse err and go to WAIT_GAP.
    - On a falling edge: classify hcnt. Below T_RUNT: pulse err, drop the bit, stay aligned, go to LOW. From T_RUNT to T_SPLIT-1: bit 0. From T_SPLIT to T_MAX: bit 1. Shift the bit into sreg and increment bitcnt, then go to LOW.
- On the 24th bit:
  - Set pixel to {sreg[22:0], bit}, pixel_idx to idx, and pulse pixel_valid.
  - Clear bitcnt and increment idx.
  - If idx == NUM_LEDS already: suppress pixel_valid, pulse err (overflow), and keep pixel and idx unchanged.
- Low-phase length is not checked.
- Simultaneous events: a word completion and an err in the same cycle are impossible by construction. frame_done and err may coincide (partial word).

## Timing
- Reset values: pixel = 0, pixel_valid = 0, pixel_idx = 0, frame_done = 0, err = 0. State is WAIT_GAP, and both synchronizer flops are 0.
- Reset mid-frame abandons everything. A fresh latch gap is required before decoding resumes.
- Latency: if din is first sampled low at edge k, din_s is low after edge k+1. The FSM acts at edge k+2, so pixel_valid is high for the cycle following edge k+2.
- frame_done asserts for the cycle after the edge where lcnt reaches RESET_CYCLES, i.e. RESET_CYCLES + 2 cycles after the pin's last fall.
- hcnt equals the exact number of cycles din was high. The driver's 8-cycle and 16-cycle pulses measure 8 and 16.
- Every strobe is exactly one cycle wide. pixel and pixel_idx hold between strobes.

## Structure
- ws2812_pkg holds the shared timing constants, CLK_HZ, bit period 25, and the T_* and RESET_CYCLES defaults, used by both the driver and this block.
- Sub-module: sync2 (two-flop synchronizer, parameterless, 1 bit). The FSM, counters and shift register stay in ws2812_rx.

## Test plan
- 1100 low, then 24 bits of 0xFF0000 (16/9 for 1, 8/17 for 0), then 1000 low -> one pixel_valid with pixel = 0xFF0000 and idx 0, then frame_done; err never asserts.
- Three pixels 0x123456, 0xABCDEF, 0x000001, then a gap -> pixel_valid ×3 with idx 0, 1, 2 and matching data, then one frame_done.
- After sync, send 12 bits then a gap -> no pixel_valid; frame_done and err pulse in the same cycle; the next full pixel gets idx 0.
- A 2-cycle runt mid-word -> err pulse and bit dropped; the 24 following valid bits still yield the correct pixel. Holding din high for 30 cycles -> err, and no decode until a 1000-cycle low.
- NUM_LEDS = 2, send 3 pixels -> two pixel_valid with idx 0 and 1; the third gives err only, with pixel unchanged.
- Assert reset after 10 bits -> outputs return to 0; bits sent without a new gap are ignored; after a gap, decoding restarts at idx 0.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants for the LED driver and the stream decoder.
// All widths and gaps are expressed in 20 MHz clk cycles.
package ws2812_pkg;

   localparam int CLK_HZ           = 20_000_000;
   localparam int BIT_PERIOD       = 25;
   localparam int DEF_T_RUNT       = 4;
   localparam int DEF_T_SPLIT      = 12;
   localparam int DEF_T_MAX        = 20;
   localparam int DEF_RESET_CYCLES = 1000;

   typedef enum logic [1:0] {
      ST_WAIT_GAP = 2'd0,
      ST_LOW      = 2'd1,
      ST_HIGH     = 2'd2
   } rx_state_t;

endpackage

// File: rtl/ws2812_rx_sync2.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;

   // metastability filter: first flop may go metastable, second is the clean copy
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_r <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 stream decoder: measures high pulses, assembles MSB-first 24-bit words
// and reports latch gaps, stuck-high lines, runts and pixel overflow.
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS     = 60,
   parameter int T_RUNT       = DEF_T_RUNT,
   parameter int T_SPLIT      = DEF_T_SPLIT,
   parameter int T_MAX        = DEF_T_MAX,
   parameter int RESET_CYCLES = DEF_RESET_CYCLES,
   parameter int IDX_W        = $clog2(NUM_LEDS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   output logic [23:0]      pixel,
   output logic             pixel_valid,
   output logic [IDX_W-1:0] pixel_idx,
   output logic             frame_done,
   output logic             err
);

   localparam int CNT_W = $clog2(RESET_CYCLES + 1);
   localparam int H_W   = $clog2(T_MAX + 1);
   // one extra code so the counter can sit at NUM_LEDS to flag overflow
   localparam int IC_W  = $clog2(NUM_LEDS + 1);

   logic             din_s;
   logic             din_q_r;
   rx_state_t        state_r, state_nx;
   logic [CNT_W-1:0] lcnt_r, lcnt_nx;
   logic [H_W-1:0]   hcnt_r, hcnt_nx;
   logic [4:0]       bitcnt_r, bitcnt_nx;
   logic [IC_W-1:0]  idx_r, idx_nx;
   logic [22:0]      sreg_r, sreg_nx;
   logic [23:0]      pixel_nx;
   logic [IDX_W-1:0] pixel_idx_nx;
   logic             pv_nx, fd_nx, err_nx;
   logic             bit_s;

   sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (din_s)
   );

   // state, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_WAIT_GAP;
         din_q_r     <= 1'b0;
         lcnt_r      <= '0;
         hcnt_r      <= '0;
         bitcnt_r    <= 5'd0;
         idx_r       <= '0;
         sreg_r      <= 23'd0;
         pixel       <= 24'd0;
         pixel_idx   <= '0;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_r     <= state_nx;
         din_q_r     <= din_s;
         lcnt_r      <= lcnt_nx;
         hcnt_r      <= hcnt_nx;
         bitcnt_r    <= bitcnt_nx;
         idx_r       <= idx_nx;
         sreg_r      <= sreg_nx;
         pixel       <= pixel_nx;
         pixel_idx   <= pixel_idx_nx;
         pixel_valid <= pv_nx;
         frame_done  <= fd_nx;
         err         <= err_nx;
      end
   end

   // next-state, pulse classification and word assembly
   always_comb begin
      state_nx     = state_r;
      lcnt_nx      = lcnt_r;
      hcnt_nx      = hcnt_r;
      bitcnt_nx    = bitcnt_r;
      idx_nx       = idx_r;
      sreg_nx      = sreg_r;
      pixel_nx     = pixel;
      pixel_idx_nx = pixel_idx;
      pv_nx        = 1'b0;
      fd_nx        = 1'b0;
      err_nx       = 1'b0;
      bit_s        = 1'b0;

      case (state_r)
         ST_WAIT_GAP: begin
            // only a full latch gap proves we are aligned to a frame start
            if (din_s) begin
               lcnt_nx = '0;
            end else if (lcnt_r == CNT_W'(RESET_CYCLES - 1)) begin
               lcnt_nx   = CNT_W'(RESET_CYCLES);
               state_nx  = ST_LOW;
               idx_nx    = '0;
               bitcnt_nx = 5'd0;
            end else begin
               lcnt_nx = lcnt_r + CNT_W'(1);
            end
         end

         ST_LOW: begin
            if (din_s && !din_q_r) begin
               state_nx = ST_HIGH;
               hcnt_nx  = H_W'(1);
               lcnt_nx  = '0;
            end else if (lcnt_r == CNT_W'(RESET_CYCLES - 1)) begin
               lcnt_nx = CNT_W'(RESET_CYCLES);
               if ((bitcnt_r != 5'd0) || (idx_r != '0)) begin
                  fd_nx  = 1'b1;
                  err_nx = (bitcnt_r != 5'd0);
               end else begin
                  fd_nx  = 1'b0;
               end
               idx_nx    = '0;
               bitcnt_nx = 5'd0;
            end else if (lcnt_r != CNT_W'(RESET_CYCLES)) begin
               lcnt_nx = lcnt_r + CNT_W'(1);
            end else begin
               lcnt_nx = lcnt_r;
            end
         end

         ST_HIGH: begin
            if (din_s) begin
               if (hcnt_r == H_W'(T_MAX)) begin
                  err_nx   = 1'b1;
                  state_nx = ST_WAIT_GAP;
                  lcnt_nx  = '0;
               end else begin
                  hcnt_nx = hcnt_r + H_W'(1);
               end
            end else begin
               state_nx = ST_LOW;
               if (hcnt_r < H_W'(T_RUNT)) begin
                  err_nx = 1'b1;
               end else begin
                  bit_s   = (hcnt_r >= H_W'(T_SPLIT));
                  sreg_nx = {sreg_r[21:0], bit_s};
                  if (bitcnt_r == 5'd23) begin
                     bitcnt_nx = 5'd0;
                     if (idx_r == IC_W'(NUM_LEDS)) begin
                        err_nx = 1'b1;
                     end else begin
                        pixel_nx     = {sreg_r, bit_s};
                        pixel_idx_nx = idx_r[IDX_W-1:0];
                        pv_nx        = 1'b1;
                        idx_nx       = idx_r + IC_W'(1);
                     end
                  end else begin
                     bitcnt_nx = bitcnt_r + 5'd1;
                  end
               end
            end
         end

         default: begin
            state_nx = ST_WAIT_GAP;
            lcnt_nx  = '0;
         end
      endcase
   end

endmodule
